// File: rtl/eyeriss_pkg.sv
// Shared definitions for the Eyeriss-style accelerator datapath blocks.
//   DATA_W        psum / ofmap word width
//   ADDR_W        ofmap SRAM address width
//   ROW_W         out_psum row-index width (p*t max)
//   COL_W         out_psum column-index width (E*F max)
//   drain_state_e ofmap_drain controller states
package eyeriss_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    READ,
    FLUSH,
    DONE
  } drain_state_e;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO that buffers returned psum words (with their ofmap address)
// between the out_psum read port and the ofmap SRAM write port.
// The head entry is presented combinationally from a register.
//   clk, rst   clock, synchronous active-high reset (clears occupancy only)
//   i_push     write i_data this cycle (never asserted while full without a pop)
//   i_data     entry to store
//   i_pop      remove head this cycle (only asserted when o_count != 0)
//   o_head     current head entry
//   o_count    occupancy, 0..2
module drain_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [1:0]       r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // r_mem0 is always the head; on a pop the second slot shifts forward.
  always_ff @(posedge clk) begin
    if (i_pop) begin
      if (r_count == 2'd2) begin
        r_mem0 <= r_mem1;
        if (i_push) begin
          r_mem1 <= i_data;
        end
      end else if (i_push) begin
        r_mem0 <= i_data;
      end
    end else if (i_push) begin
      if (r_count == 2'd0) begin
        r_mem0 <= i_data;
      end else begin
        r_mem1 <= i_data;
      end
    end
  end

  assign o_head  = r_mem0;
  assign o_count = r_count;

endmodule

// File: rtl/ofmap_drain.sv
// Drains finished partial sums from the pe_array out_psum buffer into the
// ofmap SRAM in channel-major raster order (channel, then row j, then col k).
//   clk, rst         clock, synchronous active-high reset
//   start            1-cycle pulse: pass finished, begin drain (ignored while busy)
//   p, t, R, S, H, W conv parameters (rows per filter set, filter sets, filter
//                    height/width, ifmap height/width)
//   relu_en          clamp negative psums to zero
//   ofmap_base       ofmap base address
//   psum_rd_*        out_psum read port; data returns one cycle after psum_rd_en
//   ofmap_wr_*       ofmap write port; a word moves when wr_en & wr_ready
//   busy             high from the CFG cycle to the last transfer
//   done             1-cycle pulse after the last transfer
//   cfg_err          1-cycle pulse when the config is illegal (nothing drained)
module ofmap_drain #(
  parameter int DATA_W = eyeriss_pkg::DATA_W,
  parameter int ROW_W  = eyeriss_pkg::ROW_W,
  parameter int COL_W  = eyeriss_pkg::COL_W,
  parameter int ADDR_W = eyeriss_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        p,
  input  logic [4:0]        t,
  input  logic [4:0]        R,
  input  logic [4:0]        S,
  input  logic [15:0]       H,
  input  logic [15:0]       W,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] ofmap_base,
  output logic              psum_rd_en,
  output logic [ROW_W-1:0]  psum_rd_row,
  output logic [COL_W-1:0]  psum_rd_col,
  input  logic [DATA_W-1:0] psum_rd_data,
  output logic              ofmap_wr_en,
  output logic [ADDR_W-1:0] ofmap_wr_addr,
  output logic [DATA_W-1:0] ofmap_wr_data,
  input  logic              ofmap_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  import eyeriss_pkg::*;

  localparam int FIFO_W = DATA_W + ADDR_W;

  function automatic logic signed [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] v,
                                                       input logic en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  drain_state_e r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_cfg_err;
  logic         r_relu;

  logic [15:0]      r_e_m1;
  logic [15:0]      r_f_m1;
  logic [ROW_W-1:0] r_c_m1;
  logic [4:0]       r_p;

  logic [ROW_W-1:0]  r_ch;
  logic [4:0]        r_ipos;
  logic [ROW_W-1:0]  r_grp;
  logic [ROW_W-1:0]  r_row;
  logic [15:0]       r_j;
  logic [15:0]       r_k;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;

  logic              vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;

  logic                     w_illegal;
  logic                     w_last_rd;
  logic                     w_rd_en;
  logic                     w_pop;
  logic [2:0]               w_occ;
  logic [ROW_W-1:0]         w_grp_nxt;
  logic signed [DATA_W-1:0] w_psum_p1;
  logic [FIFO_W-1:0]        w_head;
  logic [1:0]               w_count;

  assign w_illegal = ({11'd0, R} > H) || ({11'd0, S} > W) || (p == 5'd0) || (t == 5'd0);
  assign w_last_rd = (r_ch == r_c_m1) && (r_j == r_e_m1) && (r_k == r_f_m1);
  assign w_grp_nxt = r_grp + ROW_W'(r_p);

  // Words already buffered plus the one returning this cycle. A word leaving
  // through the write port in the same cycle frees its slot immediately,
  // which is what lets the drain sustain one word per cycle.
  assign w_occ   = {1'b0, w_count} + {2'b00, vld_p1};
  assign w_pop   = ofmap_wr_en && ofmap_wr_ready;
  assign w_rd_en = (r_state == READ) && ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_relu    <= 1'b0;
      vld_p1    <= 1'b0;
      r_e_m1    <= '0;
      r_f_m1    <= '0;
      r_c_m1    <= '0;
      r_p       <= '0;
      r_ch      <= '0;
      r_ipos    <= '0;
      r_grp     <= '0;
      r_row     <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_col     <= '0;
      r_addr    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      vld_p1    <= w_rd_en;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_cfg_err <= w_illegal;
            r_state   <= CFG;
          end
        end
        CFG: begin
          // r_cfg_err is high exactly in the CFG cycle of a rejected start.
          if (r_cfg_err) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_e_m1  <= H - {11'd0, R};
            r_f_m1  <= W - {11'd0, S};
            r_c_m1  <= ROW_W'(p) * ROW_W'(t) - ROW_W'(1);
            r_p     <= p;
            r_relu  <= relu_en;
            r_ch    <= '0;
            r_ipos  <= '0;
            r_grp   <= '0;
            r_row   <= ROW_W'(p) - ROW_W'(1);
            r_j     <= '0;
            r_k     <= '0;
            r_col   <= '0;
            r_addr  <= ofmap_base;
            r_state <= READ;
          end
        end
        READ: begin
          if (w_rd_en) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_k == r_f_m1) begin
              r_k <= '0;
              if (r_j == r_e_m1) begin
                r_j   <= '0;
                r_col <= '0;
                r_ch  <= r_ch + ROW_W'(1);
                // Rows run backwards inside each p-group: p-1 .. 0, then the
                // next group starts at its own top row.
                if (r_ipos == r_p - 5'd1) begin
                  r_ipos <= '0;
                  r_grp  <= w_grp_nxt;
                  r_row  <= w_grp_nxt + ROW_W'(r_p) - ROW_W'(1);
                end else begin
                  r_ipos <= r_ipos + 5'd1;
                  r_row  <= r_row - ROW_W'(1);
                end
              end else begin
                r_j   <= r_j + 16'd1;
                r_col <= r_col + COL_W'(1);
              end
            end else begin
              r_k   <= r_k + 16'd1;
              r_col <= r_col + COL_W'(1);
            end
            if (w_last_rd) begin
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (w_pop && (w_count == 2'd1) && !vld_p1) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---- p0 -> p1: read issued, address travels with the returning word ----
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_addr_p1 <= r_addr;
    end
  end

  // ---- p1: read data returns, ReLU applied, word enters the FIFO ----
  assign w_psum_p1 = relu_fn(psum_rd_data, r_relu);

  drain_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (vld_p1),
    .i_data  ({r_addr_p1, w_psum_p1}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // ---- p2: FIFO head drives the ofmap write port ----
  assign psum_rd_en    = w_rd_en;
  assign psum_rd_row   = w_rd_en ? r_row : '0;
  assign psum_rd_col   = w_rd_en ? r_col : '0;
  assign ofmap_wr_en   = (w_count != 2'd0);
  assign ofmap_wr_addr = ofmap_wr_en ? w_head[FIFO_W-1:DATA_W] : '0;
  assign ofmap_wr_data = ofmap_wr_en ? w_head[DATA_W-1:0] : '0;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_ofmap_drain.sv
// Bench for ofmap_drain: out_psum memory model, reference write-sequence model
// built from the channel/row/col loop rules, and per-cycle port monitor.
module tb_ofmap_drain;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [4:0]  p, t, R, S;
  logic [15:0] H, W;
  logic        relu_en;
  logic [15:0] ofmap_base;
  logic        psum_rd_en;
  logic [9:0]  psum_rd_row;
  logic [15:0] psum_rd_col;
  logic [15:0] psum_rd_data;
  logic        ofmap_wr_en;
  logic [15:0] ofmap_wr_addr;
  logic [15:0] ofmap_wr_data;
  logic        ofmap_wr_ready;
  logic        busy, done, cfg_err;

  always #5 clk = ~clk;

  ofmap_drain dut (
    .clk(clk), .rst(rst), .start(start),
    .p(p), .t(t), .R(R), .S(S), .H(H), .W(W),
    .relu_en(relu_en), .ofmap_base(ofmap_base),
    .psum_rd_en(psum_rd_en), .psum_rd_row(psum_rd_row), .psum_rd_col(psum_rd_col),
    .psum_rd_data(psum_rd_data),
    .ofmap_wr_en(ofmap_wr_en), .ofmap_wr_addr(ofmap_wr_addr), .ofmap_wr_data(ofmap_wr_data),
    .ofmap_wr_ready(ofmap_wr_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] mem [0:4095];
  wr_t         exp_q[$];
  int          rows_q[$];
  int          exp_rows[6] = '{2, 1, 0, 5, 4, 3};

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int rd_tot = 0, xfer_tot = 0, wr_cnt = 0, exp_total = 0;
  int done_cnt = 0, err_cnt = 0;
  int first_rd = -1, first_wr = -1, done_cyc = -1, err_cyc = -1, last_xfer_cyc = -1;
  logic [15:0] last_data = 16'h0, last_addr = 16'h0, st_addr = 16'h0, st_data = 16'h0;
  bit stall_prev = 1'b0, stall_mode = 1'b0;

  function automatic int midx(input int row, input int col);
    return (row * 64 + col) % 4096;
  endfunction

  // out_psum model: one-cycle read latency, junk when not read.
  always @(posedge clk)
    psum_rd_data <= psum_rd_en ? mem[midx(int'(psum_rd_row), int'(psum_rd_col))] : 16'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then return 1 time unit after posedge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (psum_rd_en) begin
      rd_tot++;
      rows_q.push_back(int'(psum_rd_row));
      if (first_rd < 0) first_rd = cyc;
    end
    if (ofmap_wr_en) begin
      if (first_wr < 0) first_wr = cyc;
      if (stall_prev) begin
        chk("stall_addr_stable", 32'(ofmap_wr_addr), 32'(st_addr));
        chk("stall_data_stable", 32'(ofmap_wr_data), 32'(st_data));
      end
    end
    if (ofmap_wr_en && ofmap_wr_ready) begin
      xfer_tot++;
      wr_cnt++;
      last_xfer_cyc = cyc;
      last_data = ofmap_wr_data;
      last_addr = ofmap_wr_addr;
      if (exp_q.size() == 0) begin
        chk("wr_count_overrun", wr_cnt, exp_total);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ofmap_wr_addr), 32'(e.addr));
        chk("wr_data", 32'(ofmap_wr_data), 32'(e.data));
      end
    end
    if (psum_rd_en) chk("outstanding_le2", 32'(rd_tot - xfer_tot <= 2), 32'd1);
    stall_prev = ofmap_wr_en && !ofmap_wr_ready;
    st_addr = ofmap_wr_addr;
    st_data = ofmap_wr_data;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) begin err_cnt++; err_cyc = cyc; end
    @(posedge clk);
    cyc++;
    #1;
    if (stall_mode) ofmap_wr_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: expected (addr, data) sequence straight from the loop rules.
  task automatic build_model(input int pp, tt, rr, ss, hh, ww, input bit relu, input logic [15:0] base);
    int e, f, c, row, col;
    wr_t w;
    exp_q.delete();
    exp_total = 0;
    if (rr > hh || ss > ww || pp == 0 || tt == 0) return;
    e = hh - rr + 1;
    f = ww - ss + 1;
    c = pp * tt;
    for (int i = 0; i < c; i++)
      for (int j = 0; j < e; j++)
        for (int k = 0; k < f; k++) begin
          row = (i / pp) * pp + (pp - 1 - (i % pp));
          col = j * f + k;
          w.data = mem[midx(row, col)];
          if (relu && w.data[15]) w.data = 16'h0000;
          w.addr = 16'(int'(base) + i * e * f + j * f + k);
          exp_q.push_back(w);
        end
    exp_total = c * e * f;
  endtask

  task automatic start_drain(input int pp, tt, rr, ss, hh, ww, input bit relu, input logic [15:0] base);
    build_model(pp, tt, rr, ss, hh, ww, relu, base);
    p = 5'(pp); t = 5'(tt); R = 5'(rr); S = 5'(ss); H = 16'(hh); W = 16'(ww);
    relu_en = relu;
    ofmap_base = base;
    wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_rd = -1; first_wr = -1; done_cyc = -1; err_cyc = -1;
    rows_q.delete();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_done_after_last_xfer"}, done_cyc, last_xfer_cyc + 1);
    repeat (3) tick();
    chk({tag, "_write_total"}, wr_cnt, exp_total);
    chk({tag, "_model_drained"}, exp_q.size(), 0);
    chk({tag, "_done_single"}, done_cnt, 1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_psum_rd_en"}, 32'(psum_rd_en), 32'd0);
    chk({pfx, "_psum_rd_row"}, 32'(psum_rd_row), 32'd0);
    chk({pfx, "_psum_rd_col"}, 32'(psum_rd_col), 32'd0);
    chk({pfx, "_wr_en"}, 32'(ofmap_wr_en), 32'd0);
    chk({pfx, "_wr_addr"}, 32'(ofmap_wr_addr), 32'd0);
    chk({pfx, "_wr_data"}, 32'(ofmap_wr_data), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_cfg_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int rd_before;
    rst = 1'b1; start = 1'b0;
    p = '0; t = '0; R = '0; S = '0; H = '0; W = '0;
    relu_en = 1'b0; ofmap_base = '0; ofmap_wr_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // 1: full drain, write port always ready
    start_drain(3, 4, 3, 3, 5, 5, 1'b0, 16'h0000);
    wait_done("t1", 2000);
    chk("t1_first_rd_latency", first_rd, start_cyc + 2);
    chk("t1_first_wr_latency", first_wr, start_cyc + 4);
    chk("t1_throughput_done_cyc", done_cyc, start_cyc + 4 + 108);
    for (int m = 0; m < 6; m++)
      chk($sformatf("t1_row_order_ch%0d", m), (rows_q.size() > 9 * m) ? rows_q[9 * m] : -1, exp_rows[m]);

    // 2: same drain with random write back-pressure
    stall_mode = 1'b1;
    start_drain(3, 4, 3, 3, 5, 5, 1'b0, 16'h0000);
    wait_done("t2", 3000);
    stall_mode = 1'b0;
    ofmap_wr_ready = 1'b1;
    tick();

    // 3: ReLU on a single-word drain
    mem[midx(0, 0)] = 16'hFFCE;
    start_drain(1, 1, 1, 1, 1, 1, 1'b1, 16'h0100);
    wait_done("t3a", 50);
    chk("t3_relu_neg_clamped", 32'(last_data), 32'h0000);
    mem[midx(0, 0)] = 16'h0031;
    start_drain(1, 1, 1, 1, 1, 1, 1'b1, 16'h0100);
    wait_done("t3b", 50);
    chk("t3_relu_pos_kept", 32'(last_data), 32'h0031);
    mem[midx(0, 0)] = 16'hFFCE;
    start_drain(1, 1, 1, 1, 1, 1, 1'b0, 16'h0100);
    wait_done("t3c", 50);
    chk("t3_relu_off_neg_kept", 32'(last_data), 32'hFFCE);

    // 4: illegal config R > H
    rd_before = rd_tot;
    start_drain(3, 4, 6, 3, 5, 5, 1'b0, 16'h0000);
    repeat (10) tick();
    chk("t4_cfg_err_count", err_cnt, 1);
    chk("t4_cfg_err_cycle", err_cyc, start_cyc + 1);
    chk("t4_no_reads", rd_tot, rd_before);
    chk("t4_no_writes", wr_cnt, 0);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_busy_low", 32'(busy), 32'd0);

    // 5: base address near the top wraps around
    start_drain(3, 4, 5, 5, 5, 5, 1'b0, 16'hFFFA);
    wait_done("t5", 200);
    chk("t5_last_addr_wrapped", 32'(last_addr), 32'h0005);

    // 6: reset mid-drain, then a clean re-drain with an ignored second start
    start_drain(3, 4, 3, 3, 5, 5, 1'b0, 16'h0000);
    for (int n = 0; n < 600 && wr_cnt < 40; n++) tick();
    chk("t6_reached_40_writes", 32'(wr_cnt >= 40), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outputs_zero("t6_after_rst");
    exp_q.delete();
    exp_total = 0;
    rd_tot = 0; xfer_tot = 0; stall_prev = 1'b0; done_cnt = 0;
    wr_cnt = 0;
    repeat (4) tick();
    chk("t6_no_done_after_abort", done_cnt, 0);
    start_drain(3, 4, 3, 3, 5, 5, 1'b0, 16'h0000);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6", 2000);
    chk("t6_second_start_no_err", err_cnt, 0);
    chk("t6_first_rd_latency", first_rd, start_cyc + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
